// File: rtl/alu_modred_pkg.sv
// Shared types and constants for the alu_modred_seq modular-reduction sequencer.
// The optional quotient register is enabled by defining ALU_MODRED_QUOTIENT_EN.
package alu_modred_pkg;

    localparam int MODRED_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } modred_state_t;

    // Bit counter must index dividend bits N-1..0; keep at least one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_modred_seq_if.sv
// Request/result bundle between the exponentiation control and alu_modred_seq.
// Defining ALU_MODRED_QUOTIENT_EN leaves this port list unchanged.
interface alu_modred_if
    import alu_modred_pkg::*;
    #(parameter int N = MODRED_N)
    ();

    // start is a single-cycle request honoured only while busy is low; a and n
    // are sampled on that cycle. done pulses once; r/q/err hold until next start.
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] n;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] r;
    logic [N-1:0] q;

    modport master (output start, a, n, input busy, done, err, r, q);
    modport slave  (input start, a, n, output busy, done, err, r, q);

endinterface

// File: rtl/alu_modred_seq_sub_cell.sv
// Invert-plus-carry adder/subtractor; with sub high, bit W-1 of sum is the borrow.
module alu_sub_cell #(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum
);

    assign sum = x + (sub ? ~y : y) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/alu_modred_seq.sv
// Restoring shift-and-subtract reducer: r = a mod n (and q = a / n when
// ALU_MODRED_QUOTIENT_EN is defined), one dividend bit per clock.
module alu_modred_seq
    import alu_modred_pkg::*;
    #(parameter int N = MODRED_N)
    (
    input  logic          clk,
    input  logic          rst_n,
    alu_modred_if.slave   bus,
    output modred_state_t dbg_state
);

    localparam int CNT_W = cnt_width(N);

    modred_state_t     r_state;
    modred_state_t     w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [N:0]        r_rem;
    logic [N-1:0]      r_dividend;
    logic [N-1:0]      r_modulus;
    logic [N-1:0]      r_r;
    logic              r_err;
    logic [N:0]        w_t;
    logic [N:0]        w_diff;
    logic              w_ge;
    logic              w_accept;
    logic              w_nzero;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_nzero  = (bus.n == '0);
    assign w_t      = {r_rem[N-1:0], r_dividend[r_cnt]};

    alu_sub_cell #(.W(N+1)) u_sub (
        .x   (w_t),
        .y   ({1'b0, r_modulus}),
        .sub (1'b1),
        .sum (w_diff)
    );

    // No borrow out of the top bit means t >= n.
    assign w_ge = ~w_diff[N];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = w_nzero ? DONE : RUN;
            RUN:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dividend <= '0;
            r_modulus  <= '0;
            r_r        <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= bus.a;
            r_modulus  <= bus.n;
            r_rem      <= '0;
            r_cnt      <= w_nzero ? '0 : CNT_W'(N-1);
            r_err      <= w_nzero;
            if (w_nzero) r_r <= bus.a;
        end else if (r_state == RUN) begin
            r_rem <= w_ge ? w_diff : w_t;
            if (r_cnt == '0) r_r <= w_ge ? w_diff[N-1:0] : w_t[N-1:0];
            else             r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef ALU_MODRED_QUOTIENT_EN
    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_q <= '0;
        else if (w_accept)          r_q <= w_nzero ? '1 : '0;
        else if (r_state == RUN)    r_q[r_cnt] <= w_ge;
    end

    assign bus.q = r_q;
`else
    assign bus.q = '0;
`endif

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
    assign bus.err  = r_err;
    assign bus.r    = r_r;
    assign dbg_state = r_state;

endmodule

// File: doc/alu_modred_seq.md
# alu_modred_seq

Multi-cycle sequencer that computes r = a mod n, and optionally q = a / n, for the RSA decryption datapath. It uses restoring shift-and-subtract and resolves one dividend bit per clock. Each subtraction is formed as invert-plus-carry-in on the modulus. It sits beside the EX-stage ALU and is started by the exponentiation/control logic whenever a product must be reduced modulo n.

## Interface
- N, 32, operand width in bits (≥ 2)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only in IDLE
- a  input  N  dividend, captured on accepted start
- n  input  N  modulus, captured on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse when the result is valid
- err  output  1  divide-by-zero flag; valid with done, held until next accepted start
- r  output  N  remainder; held until next accepted start
- q  output  N  quotient; held until next accepted start (see Configuration)

## Operation
- States: IDLE, RUN, DONE (typedef in package).
- IDLE
  - start=1: capture a→dividend register, n→modulus register; clear rem (N+1 bits), cnt, q, err.
  - If n==0: go to DONE with err=1, r=a, q=all ones.
  - Otherwise go to RUN with cnt=N-1.
- RUN, per cycle, bit i=cnt:
  - t = {rem[N-1:0], dividend[i]} (N+1 bits).
  - diff = t + ~{1'b0,n} + 1, computed in N+1 bits.
  - diff[N]==0 (t ≥ n): rem←diff, q[i]←1. Otherwise rem←t, q[i]←0.
  - cnt==0: go to DONE and load r←final rem[N-1:0]. Otherwise cnt←cnt-1.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored, with no queueing; a and n may change freely while busy.
- Remainder never exceeds n-1 < 2^N, so r fits in N bits. No overflow case exists.

## Timing
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, err=0, r=0, q=0, rem=0, cnt=0.
- Start sampled at edge E0 → busy=1 after E0.
  - RUN occupies N cycles (E1..EN).
  - done=1 during the cycle after EN; r and q are valid from that cycle.
  - Total start-to-done latency: N+1 cycles.
  - Back-to-back: next start accepted in the cycle after done, so throughput is one operation per N+2 cycles.
- n==0: done asserted the cycle after E0 (latency 1).
- start in the same cycle as done is ignored (state is DONE).
- Reset mid-operation: immediate return to reset values; the partial result is discarded and no done pulse is issued.
- Outputs r, q, err, done, busy are all registered; no combinational path from inputs to outputs.

## Configuration
- ALU_MODRED_QUOTIENT_EN defined:
  - quotient register implemented; q carries a / n.
  - n==0 gives q = all ones.
- Not defined:
  - quotient register removed; q tied to 0 in all cases.
  - port list unchanged.
  - remainder, latency and err behaviour identical.

## Structure
- Package alu_modred_pkg:
  - state enum modred_state_t {IDLE, RUN, DONE}
  - default width constant MODRED_N = 32
  - counter width function/localparam ($clog2(N))
- Sub-module alu_sub_cell (parameter W = N+1):
  - inputs x, y; subtract control.
  - output sum[W-1:0] = x + (sub ? ~y : y) + sub; borrow is read from bit W-1.
  - Instantiated once; sub tied high.
- Top level: state register, counter, rem/dividend/modulus/q registers, output registers.

## Test plan
- N=32, a=100, n=7, start pulse → done exactly 33 cycles after the start edge; r=2, q=14, err=0.
- a=5, n=9 → r=5, q=0, err=0.
- a=0xFFFFFFFF, n=1 → r=0, q=0xFFFFFFFF. Then a=0xFFFFFFFF, n=0xFFFFFFFF → r=0, q=1.
- a=1234, n=0 → done the cycle after start; err=1, r=1234, q=0xFFFFFFFF (q=0 without macro).
- a=1000, n=3 started; start re-pulsed at cycles 5 and 33 with a=7, n=2 → both ignored; result r=1, q=333. Second start after done → r=1, q=3.
- rst_n pulsed low mid-RUN (cycle 10) → busy, done, r, q, err = 0 asynchronously; no done pulse; next start computes correctly.
